// File: rtl/grid_renderer.sv
// Tile-grid renderer: walks a rectangular region of the grid memory and paints each
// cell as a 2^CELL_LOG2 square of pixels, one pixel per cycle, with optional colour-key skip.
module grid_renderer #(
    parameter int GRID_W    = 40,
    parameter int GRID_H    = 30,
    parameter int GX_W      = 6,
    parameter int GY_W      = 5,
    parameter int CELL_LOG2 = 2,
    parameter int COLOUR_W  = 3,
    parameter int X_W       = 8,
    parameter int Y_W       = 7
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [GX_W-1:0]     rx0,
    input  logic [GX_W-1:0]     rx1,
    input  logic [GY_W-1:0]     ry0,
    input  logic [GY_W-1:0]     ry1,
    input  logic                skip_en,
    input  logic [COLOUR_W-1:0] skip_colour,
    output logic                busy,
    output logic                done,
    output logic [GX_W-1:0]     grid_x,
    output logic [GY_W-1:0]     grid_y,
    input  logic [COLOUR_W-1:0] grid_out,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_write
);

    localparam int PW = (CELL_LOG2 > 0) ? CELL_LOG2 : 1;
    localparam logic [PW-1:0] P_LAST = PW'((1 << CELL_LOG2) - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        DRAW  = 3'd3,
        NEXT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t              state_r;
    logic [GX_W-1:0]     rx0_r;
    logic [GX_W-1:0]     rx1_r;
    logic [GY_W-1:0]     ry0_r;
    logic [GY_W-1:0]     ry1_r;
    logic                skip_en_r;
    logic [COLOUR_W-1:0] skip_colour_r;
    logic [COLOUR_W-1:0] colour_r;
    logic [PW-1:0]       px_r;
    logic [PW-1:0]       py_r;

    logic                region_valid_s;
    logic [X_W-1:0]      base_x_s;
    logic [Y_W-1:0]      base_y_s;
    logic                row_end_s;
    logic                cell_end_s;
    logic [PW-1:0]       px_next_s;
    logic [PW-1:0]       py_next_s;

    // Bounds are compared at 32 bits so a GRID_W that fills GX_W cannot wrap.
    assign region_valid_s = (rx0 <= rx1) && (int'(rx1) < GRID_W) &&
                            (ry0 <= ry1) && (int'(ry1) < GRID_H);
    assign base_x_s   = X_W'(grid_x) << CELL_LOG2;
    assign base_y_s   = Y_W'(grid_y) << CELL_LOG2;
    assign row_end_s  = (px_r == P_LAST);
    assign cell_end_s = row_end_s && (py_r == P_LAST);
    assign px_next_s  = row_end_s ? {PW{1'b0}} : px_r + PW'(1);
    assign py_next_s  = row_end_s ? py_r + PW'(1) : py_r;

    // Render sequencer with all outputs registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            vga_write     <= 1'b0;
            grid_x        <= {GX_W{1'b0}};
            grid_y        <= {GY_W{1'b0}};
            vga_x         <= {X_W{1'b0}};
            vga_y         <= {Y_W{1'b0}};
            vga_colour    <= {COLOUR_W{1'b0}};
            px_r          <= {PW{1'b0}};
            py_r          <= {PW{1'b0}};
            rx0_r         <= {GX_W{1'b0}};
            rx1_r         <= {GX_W{1'b0}};
            ry0_r         <= {GY_W{1'b0}};
            ry1_r         <= {GY_W{1'b0}};
            skip_en_r     <= 1'b0;
            skip_colour_r <= {COLOUR_W{1'b0}};
            colour_r      <= {COLOUR_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        rx0_r         <= rx0;
                        rx1_r         <= rx1;
                        ry0_r         <= ry0;
                        ry1_r         <= ry1;
                        skip_en_r     <= skip_en;
                        skip_colour_r <= skip_colour;
                        busy          <= 1'b1;
                        if (region_valid_s) begin
                            grid_x  <= rx0;
                            grid_y  <= ry0;
                            state_r <= FETCH;
                        end else begin
                            done    <= 1'b1;
                            state_r <= DONE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FETCH: begin
                    state_r <= LATCH;
                end
                LATCH: begin
                    colour_r <= grid_out;
                    if (skip_en_r && (grid_out == skip_colour_r)) begin
                        state_r <= NEXT;
                    end else begin
                        px_r       <= {PW{1'b0}};
                        py_r       <= {PW{1'b0}};
                        vga_x      <= base_x_s;
                        vga_y      <= base_y_s;
                        vga_colour <= grid_out;
                        vga_write  <= 1'b1;
                        state_r    <= DRAW;
                    end
                end
                DRAW: begin
                    // Coordinates are precomputed so each pixel appears in the cycle it is written.
                    if (cell_end_s) begin
                        vga_write <= 1'b0;
                        state_r   <= NEXT;
                    end else begin
                        px_r  <= px_next_s;
                        py_r  <= py_next_s;
                        vga_x <= base_x_s + X_W'(px_next_s);
                        vga_y <= base_y_s + Y_W'(py_next_s);
                    end
                end
                NEXT: begin
                    if ((grid_x == rx1_r) && (grid_y == ry1_r)) begin
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else if (grid_x == rx1_r) begin
                        grid_x  <= rx0_r;
                        grid_y  <= grid_y + GY_W'(1);
                        state_r <= FETCH;
                    end else begin
                        grid_x  <= grid_x + GX_W'(1);
                        state_r <= FETCH;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    vga_write <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grid_renderer.sv
// Randomised self-checking bench for grid_renderer: a default instance and a
// CELL_LOG2=3 20x15 instance, both checked against a region-walk reference model.
module tb_grid_renderer;

    typedef logic [17:0] pix_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [5:0] rx0 = 6'd0, rx1 = 6'd0;
    logic [4:0] ry0 = 5'd0, ry1 = 5'd0;
    logic       skip_en = 1'b0;
    logic [2:0] skip_colour = 3'd0;

    logic       a_busy, a_done, a_write, b_busy, b_done, b_write;
    logic [5:0] a_gx, b_gx;
    logic [4:0] a_gy, b_gy;
    logic [2:0] a_gout, b_gout, a_col, b_col;
    logic [7:0] a_x, b_x;
    logic [6:0] a_y, b_y;

    logic [2:0] mem [0:29][0:39];

    int   total = 0;
    int   bad = 0;
    bit   use_b = 1'b0;
    pix_t exp_q[$];
    pix_t got_q[$];
    int   exp_done;
    int   done_at;
    int   busy_low;
    bit   post_done;
    bit   post_busy;

    always #5 clock = ~clock;

    grid_renderer dut_a (
        .clock(clock), .reset(reset), .start(start_a),
        .rx0(rx0), .rx1(rx1), .ry0(ry0), .ry1(ry1),
        .skip_en(skip_en), .skip_colour(skip_colour),
        .busy(a_busy), .done(a_done), .grid_x(a_gx), .grid_y(a_gy),
        .grid_out(a_gout), .vga_x(a_x), .vga_y(a_y),
        .vga_colour(a_col), .vga_write(a_write)
    );

    grid_renderer #(.GRID_W(20), .GRID_H(15), .CELL_LOG2(3)) dut_b (
        .clock(clock), .reset(reset), .start(start_b),
        .rx0(rx0), .rx1(rx1), .ry0(ry0), .ry1(ry1),
        .skip_en(skip_en), .skip_colour(skip_colour),
        .busy(b_busy), .done(b_done), .grid_x(b_gx), .grid_y(b_gy),
        .grid_out(b_gout), .vga_x(b_x), .vga_y(b_y),
        .vga_colour(b_col), .vga_write(b_write)
    );

    // Synchronous grid memory, one read port per instance.
    always @(posedge clock) begin
        if (a_gx < 6'd40 && a_gy < 5'd30) a_gout <= mem[a_gy][a_gx];
        if (b_gx < 6'd40 && b_gy < 5'd30) b_gout <= mem[b_gy][b_gx];
    end

    task automatic fill_const(input int c);
        for (int y = 0; y < 30; y++)
            for (int x = 0; x < 40; x++) mem[y][x] = 3'(c);
    endtask

    task automatic fill_random(input int maxc);
        for (int y = 0; y < 30; y++)
            for (int x = 0; x < 40; x++) mem[y][x] = 3'($urandom_range(0, maxc));
    endtask

    // Expected pixel stream and done cycle straight from the region/cell rules.
    task automatic model(input int lg, input int w, input int h, input int x0, input int x1,
                         input int y0, input int y1, input bit se, input int sc);
        int n = 1 << lg;
        int cells = 0;
        int drawn = 0;
        exp_q.delete();
        if (x0 > x1 || x1 >= w || y0 > y1 || y1 >= h) begin
            exp_done = 1;
            return;
        end
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                cells++;
                if (se && int'(mem[y][x]) == sc) continue;
                drawn++;
                for (int py = 0; py < n; py++)
                    for (int px = 0; px < n; px++)
                        exp_q.push_back({8'(x * n + px), 7'(y * n + py), mem[y][x]});
            end
        end
        exp_done = cells * 3 + drawn * n * n + 1;
    endtask

    // Starts one render and records writes, done cycle and busy until done (or timeout).
    task automatic run_render(input int x0, input int x1, input int y0, input int y1,
                              input bit se, input int sc, input bit poke);
        int cyc = 0;
        rx0 = 6'(x0); rx1 = 6'(x1); ry0 = 5'(y0); ry1 = 5'(y1);
        skip_en = se; skip_colour = 3'(sc);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clock);
        #1;
        start_a = 1'b0; start_b = 1'b0;
        got_q.delete();
        done_at = 0;
        busy_low = 0;
        while (done_at == 0 && cyc < 30000) begin
            @(negedge clock);
            cyc++;
            if (use_b ? b_write : a_write)
                got_q.push_back(use_b ? {b_x, b_y, b_col} : {a_x, a_y, a_col});
            if (!(use_b ? b_busy : a_busy)) busy_low++;
            if (use_b ? b_done : a_done) done_at = cyc;
            if (poke && cyc == 3) begin
                rx0 = 6'($urandom_range(0, 39)); rx1 = 6'($urandom_range(0, 39));
                ry0 = 5'($urandom_range(0, 29)); ry1 = 5'($urandom_range(0, 29));
                skip_en = ~se; skip_colour = 3'($urandom_range(0, 7));
                start_a = 1'b1;
            end else if (poke && cyc == 4) begin
                start_a = 1'b0;
            end
        end
        start_a = 1'b0;
        @(negedge clock);
        post_done = use_b ? b_done : a_done;
        post_busy = use_b ? b_busy : a_busy;
    endtask

    task automatic compare_common(input string name);
        int seq_bad = 0;
        int first = -1;
        total++;
        if (done_at !== exp_done) begin
            bad++;
            $display("FAIL %s done_cycle: got %0d expected %0d", name, done_at, exp_done);
        end
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL %s write_count: got %0d expected %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) begin
                seq_bad++;
                if (first < 0) first = i;
            end
        total++;
        if (seq_bad !== 0) begin
            bad++;
            $display("FAIL %s pixel_seq: %0d wrong, first at %0d got %h expected %h",
                     name, seq_bad, first, got_q[first], exp_q[first]);
        end
        total++;
        if (busy_low !== 0 || post_busy !== 1'b0 || post_done !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_done: busy_low=%0d post_busy=%b post_done=%b expected 0/0/0",
                     name, busy_low, post_busy, post_done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        total++;
        if ({a_busy, a_done, a_write, a_gx, a_gy, a_x, a_y, a_col} !== 33'd0) begin
            bad++;
            $display("FAIL reset_a: got busy=%b done=%b wr=%b gx=%0d gy=%0d x=%0d y=%0d c=%0d expected all 0",
                     a_busy, a_done, a_write, a_gx, a_gy, a_x, a_y, a_col);
        end
        total++;
        if ({b_busy, b_done, b_write, b_x, b_y} !== 18'd0) begin
            bad++;
            $display("FAIL reset_b: got busy=%b done=%b wr=%b x=%0d y=%0d expected all 0",
                     b_busy, b_done, b_write, b_x, b_y);
        end
        reset = 1'b0;
    endtask

    task automatic test_full_frame();
        fill_const(5);
        model(2, 40, 30, 0, 39, 0, 29, 1'b0, 0);
        run_render(0, 39, 0, 29, 1'b0, 0, 1'b0);
        compare_common("full_frame");
        total++;
        if (got_q.size() != 19200 || done_at != 22801) begin
            bad++;
            $display("FAIL full_frame_totals: got writes=%0d done=%0d expected 19200 22801",
                     got_q.size(), done_at);
        end
    endtask

    task automatic test_single_cell();
        fill_random(7);
        mem[2][3] = 3'd6;
        model(2, 40, 30, 3, 3, 2, 2, 1'b0, 0);
        run_render(3, 3, 2, 2, 1'b0, 0, 1'b0);
        compare_common("single_cell");
    endtask

    task automatic test_skip_corner();
        int hits = 0;
        fill_const(7);
        mem[28][39] = 3'd0;
        model(2, 40, 30, 38, 39, 28, 29, 1'b1, 0);
        run_render(38, 39, 28, 29, 1'b1, 0, 1'b0);
        compare_common("skip_corner");
        foreach (got_q[i])
            if (got_q[i][17:10] >= 8'd156 && got_q[i][9:3] >= 7'd112 && got_q[i][9:3] <= 7'd115)
                hits++;
        total++;
        if (hits !== 0 || done_at !== 61) begin
            bad++;
            $display("FAIL skip_hole: got %0d pixels in skipped cell, done %0d expected 0, 61", hits, done_at);
        end
    endtask

    task automatic test_invalid();
        model(2, 40, 30, 5, 4, 0, 0, 1'b0, 0);
        run_render(5, 4, 0, 0, 1'b0, 0, 1'b0);
        compare_common("invalid_x");
        model(2, 40, 30, 0, 40, 3, 3, 1'b0, 0);
        run_render(0, 40, 3, 3, 1'b0, 0, 1'b0);
        compare_common("invalid_bound");
        model(2, 40, 30, 2, 2, 7, 6, 1'b0, 0);
        run_render(2, 2, 7, 6, 1'b0, 0, 1'b0);
        compare_common("invalid_y");
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            int x0 = $urandom_range(0, 39);
            int y0 = $urandom_range(0, 29);
            int x1 = (x0 + $urandom_range(0, 4) > 39) ? 39 : x0 + $urandom_range(0, 4);
            int y1 = (y0 + $urandom_range(0, 4) > 29) ? 29 : y0 + $urandom_range(0, 4);
            bit se = 1'($urandom_range(0, 1));
            int sc = $urandom_range(0, 3);
            fill_random(3);
            model(2, 40, 30, x0, x1, y0, y1, se, sc);
            run_render(x0, x1, y0, y1, se, sc, 1'b1);
            compare_common($sformatf("random%0d", k));
        end
    endtask

    task automatic test_back_to_back();
        fill_random(7);
        model(2, 40, 30, 10, 11, 4, 4, 1'b0, 0);
        run_render(10, 11, 4, 4, 1'b0, 0, 1'b0);
        compare_common("b2b_first");
        model(2, 40, 30, 0, 0, 0, 1, 1'b1, int'(mem[0][0]));
        run_render(0, 0, 0, 1, 1'b1, int'(mem[0][0]), 1'b0);
        compare_common("b2b_second");
    endtask

    task automatic test_reset_mid();
        int late = 0;
        fill_const(2);
        rx0 = 6'd0; rx1 = 6'd39; ry0 = 5'd0; ry1 = 5'd29; skip_en = 1'b0;
        start_a = 1'b1;
        @(posedge clock);
        #1;
        start_a = 1'b0;
        repeat (1000) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        total++;
        if (a_write !== 1'b0 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: got write=%b busy=%b expected 0 0", a_write, a_busy);
        end
        repeat (40) begin
            @(negedge clock);
            if (a_done || a_write || a_busy) late++;
        end
        total++;
        if (late !== 0) begin
            bad++;
            $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", late);
        end
        fill_random(7);
        model(2, 40, 30, 0, 3, 0, 2, 1'b0, 0);
        run_render(0, 3, 0, 2, 1'b0, 0, 1'b0);
        compare_common("after_reset");
    endtask

    task automatic test_variant();
        use_b = 1'b1;
        fill_random(7);
        model(3, 20, 15, 0, 19, 0, 14, 1'b0, 0);
        run_render(0, 19, 0, 14, 1'b0, 0, 1'b0);
        compare_common("variant_full");
        total++;
        if (got_q.size() != 19200 || done_at != 20101) begin
            bad++;
            $display("FAIL variant_totals: got writes=%0d done=%0d expected 19200 20101",
                     got_q.size(), done_at);
        end
        use_b = 1'b0;
    endtask

    initial begin
        fill_const(0);
        test_reset();
        @(negedge clock);
        test_single_cell();
        test_skip_corner();
        test_invalid();
        test_random();
        test_back_to_back();
        test_full_frame();
        test_reset_mid();
        test_variant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
